// File: rtl/ram_copy_engine.sv
// Block copy / constant fill sequencer driving one single-port RAM.
// Copy costs three cycles per word (read, capture, write); fill costs one.
module ram_copy_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic [DATA_WIDTH-1:0] i_fill_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_addr_ram,
  output logic [DATA_WIDTH-1:0] o_wdata_ram,
  output logic                  o_en_ram,
  output logic                  o_we_ram,
  output logic                  o_re_ram,
  input  logic [DATA_WIDTH-1:0] i_rdata_ram
);

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_FILL,
    ST_DONE
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] src_ptr_reg;
  logic [ADDR_WIDTH-1:0] dst_ptr_reg;
  logic [ADDR_WIDTH:0]   cnt_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  en_reg;
  logic                  we_reg;
  logic                  re_reg;

  logic [ADDR_WIDTH-1:0] src_ptr_next;
  logic [ADDR_WIDTH-1:0] dst_ptr_next;
  logic [ADDR_WIDTH:0]   cnt_next;

  // Pointers are ADDR_WIDTH wide, so the increment wraps naturally.
  assign src_ptr_next = src_ptr_reg + PTR_ONE;
  assign dst_ptr_next = dst_ptr_reg + PTR_ONE;
  assign cnt_next     = cnt_reg - LEN_ONE;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      en_reg      <= 1'b0;
      we_reg      <= 1'b0;
      re_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            src_ptr_reg <= i_src_addr;
            dst_ptr_reg <= i_dst_addr;
            cnt_reg     <= i_len;
            if (i_len > DEPTH) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else if (i_len == LEN_ZERO) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (i_mode) begin
              state_reg <= ST_FILL;
              busy_reg  <= 1'b1;
              en_reg    <= 1'b1;
              we_reg    <= 1'b1;
              addr_reg  <= i_dst_addr;
              wdata_reg <= i_fill_data;
            end else begin
              state_reg <= ST_RD;
              busy_reg  <= 1'b1;
              en_reg    <= 1'b1;
              re_reg    <= 1'b1;
              addr_reg  <= i_src_addr;
            end
          end
        end
        ST_RD: begin
          state_reg <= ST_CAP;
          en_reg    <= 1'b0;
          re_reg    <= 1'b0;
        end
        ST_CAP: begin
          // The write-data register doubles as the hold register for the read word.
          state_reg <= ST_WR;
          wdata_reg <= i_rdata_ram;
          en_reg    <= 1'b1;
          we_reg    <= 1'b1;
          addr_reg  <= dst_ptr_reg;
        end
        ST_WR: begin
          src_ptr_reg <= src_ptr_next;
          dst_ptr_reg <= dst_ptr_next;
          cnt_reg     <= cnt_next;
          we_reg      <= 1'b0;
          if (cnt_reg == LEN_ONE) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= ST_RD;
            re_reg    <= 1'b1;
            addr_reg  <= src_ptr_next;
          end
        end
        ST_FILL: begin
          dst_ptr_reg <= dst_ptr_next;
          cnt_reg     <= cnt_next;
          if (cnt_reg == LEN_ONE) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            en_reg    <= 1'b0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            addr_reg <= dst_ptr_next;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_reg;
  assign o_done      = done_reg;
  assign o_err       = err_reg;
  assign o_addr_ram  = addr_reg;
  assign o_wdata_ram = wdata_reg;
  assign o_en_ram    = en_reg;
  assign o_we_ram    = we_reg;
  assign o_re_ram    = re_reg;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine: a behavioural RAM plus a reference
// copy/fill model whose expectations are queued at start and checked after completion.
module tb_ram_copy_engine;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  localparam int K_DONE_CYC = 0;
  localparam int K_ERR      = 1;
  localparam int K_BUSY     = 2;
  localparam int K_EN       = 3;
  localparam int K_DONES    = 4;
  localparam int K_BOTH     = 5;
  localparam int K_MEM      = 6;

  typedef struct {
    int kind;
    int idx;
    int val;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] addr_ram;
  logic [DW-1:0] wdata_ram;
  logic          en_ram;
  logic          we_ram;
  logic          re_ram;
  logic [DW-1:0] rdata_ram;

  logic [DW-1:0] mem [DEPTH];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [17:0]   outs;
  assign outs = {busy, done, err, addr_ram, wdata_ram, en_ram, we_ram, re_ram};

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  ram_copy_engine #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_mode     (mode),
    .i_src_addr (src),
    .i_dst_addr (dst),
    .i_len      (len),
    .i_fill_data(fill),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_addr_ram (addr_ram),
    .o_wdata_ram(wdata_ram),
    .o_en_ram   (en_ram),
    .o_we_ram   (we_ram),
    .o_re_ram   (re_ram),
    .i_rdata_ram(rdata_ram)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write at end of the command cycle, read data valid the next cycle.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (en_ram && we_ram) mem[addr_ram] <= wdata_ram;
    if (en_ram && re_ram) rdata_ram <= mem[addr_ram];
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input int v);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = AW'(a);
    bd_data = DW'(v);
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_op(input logic m, input int s, input int d, input int l, input int f,
                        input int inj_cyc, input int rst_cyc);
    logic [DW-1:0] snap [DEPTH];
    int words, exp_done, exp_busy, exp_en, exp_dones;
    int done_cyc, err_obs, busy_n, en_n, both_n, done_n, obs;
    bit rst_pending;
    exp_t e;

    for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
    if (l > DEPTH || l == 0) begin
      words = 0; exp_done = 1; exp_busy = 0; exp_en = 0;
    end else if (m) begin
      words = l; exp_done = l + 1; exp_busy = l; exp_en = l;
    end else begin
      words = l; exp_done = 3 * l + 1; exp_busy = 3 * l; exp_en = 2 * l;
    end
    exp_dones = 1;
    if (rst_cyc > 0) begin
      words = rst_cyc / 3; exp_done = -1; exp_busy = rst_cyc; exp_dones = 0; exp_en = 0;
      for (int c = 1; c <= rst_cyc; c++) if (c % 3 != 2) exp_en++;
    end
    for (int i = 0; i < words; i++) begin
      if (m) snap[(d + i) % DEPTH] = DW'(f);
      else   snap[(d + i) % DEPTH] = snap[(s + i) % DEPTH];
    end

    sb_q.push_back('{K_DONE_CYC, 0, exp_done});
    sb_q.push_back('{K_ERR, 0, (l > DEPTH) ? 1 : 0});
    sb_q.push_back('{K_BUSY, 0, exp_busy});
    sb_q.push_back('{K_EN, 0, exp_en});
    sb_q.push_back('{K_DONES, 0, exp_dones});
    sb_q.push_back('{K_BOTH, 0, 0});
    for (int i = 0; i < DEPTH; i++) sb_q.push_back('{K_MEM, i, int'(snap[i])});

    @(negedge clk);
    mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(l); fill = DW'(f); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    done_cyc = -1; err_obs = 0; busy_n = 0; en_n = 0; both_n = 0; done_n = 0;
    rst_pending = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (rst_pending) begin
        check_val("outs_after_reset", int'(outs), 0);
        rst_n = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (en_ram) en_n++;
      if (we_ram && re_ram) both_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = c;
          err_obs  = int'(err);
        end
      end
      if (c == inj_cyc) begin
        start = 1'b1;
        src   = ~src;
      end
      if (inj_cyc > 0 && c == inj_cyc + 1) start = 1'b0;
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        rst_pending = 1'b1;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    @(negedge clk);

    $display("op mode=%0d src=%0d dst=%0d len=%0d fill=%0d: done_cyc=%0d err=%0d busy=%0d en=%0d",
             m, s, d, l, f, done_cyc, err_obs, busy_n, en_n);

    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_DONE_CYC: check_val("done_cycle", done_cyc, e.val);
        K_ERR:      check_val("err", err_obs, e.val);
        K_BUSY:     check_val("busy_cycles", busy_n, e.val);
        K_EN:       check_val("en_cycles", en_n, e.val);
        K_DONES:    check_val("done_pulses", done_n, e.val);
        K_BOTH:     check_val("we_re_overlap", both_n, e.val);
        default: begin
          obs = int'(mem[e.idx]);
          check_val($sformatf("mem[%0d]", e.idx), obs, e.val);
        end
      endcase
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    src = '0; dst = '0; len = '0; fill = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_outs", int'(outs), 0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) preload(i, 8'h40 + i);
    preload(0, 12);
    preload(3, 5);
    preload(6, 15);
    run_op(1'b0, 0, 8, 7, 0, 0, 0);          // copy, done in cycle 22
    run_op(1'b1, 0, 14, 4, 8'hA5, 0, 0);     // fill wrapping past the top
    run_op(1'b0, 1, 2, 0, 0, 0, 0);          // zero length
    run_op(1'b0, 1, 2, 17, 0, 0, 0);         // rejected length

    preload(2, 7);
    run_op(1'b0, 2, 3, 3, 0, 0, 0);          // forward overlap propagation

    for (int i = 4; i < 8; i++) preload(i, 8'h90 + i);
    run_op(1'b0, 4, 10, 4, 0, 2, 0);         // second start and src change ignored

    preload(0, 8'h61);
    preload(1, 8'h62);
    run_op(1'b0, 0, 12, 4, 0, 0, 5);         // reset in cycle 5
    run_op(1'b0, 12, 1, 2, 0, 0, 0);         // normal copy after reset

    run_op(1'b1, 0, 5, 16, 8'h3C, 0, 0);     // full-depth fill

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
